// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scan-out, a CPU port and a
// screen-clear engine. The display owns every 2^SHIFT-th visible pixel; CPU beats clear otherwise.
module vga_fb_arbiter #(
  parameter int FB_W  = 160,
  parameter int FB_H  = 120,
  parameter int SHIFT = 2,
  parameter int AW    = 15,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          cpu_valid,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] FB_W_A  = AW'(FB_W);
  localparam logic [AW-1:0] FB_LAST = AW'(FB_W * FB_H - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_color;
  logic          r_busy;
  logic          r_done;
  logic          r_disp_rd;
  logic          r_act_d1;
  logic [DW-1:0] r_pix_data;
  logic          r_pix_valid;
  logic          r_rd_pend;
  logic          r_rd_oor;
  logic [DW-1:0] r_rdata;

  logic          w_slot;
  logic          w_cpu_acc;
  logic          w_cpu_inrange;
  logic          w_clr_grant;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_disp_addr;
  logic [DW-1:0] w_rd_val;

  assign w_slot        = active && (x[SHIFT-1:0] == '0);
  assign w_row         = AW'(y >> SHIFT);
  assign w_col         = AW'(x >> SHIFT);
  assign w_disp_addr   = w_row * FB_W_A + w_col;
  assign w_cpu_inrange = (cpu_addr <= FB_LAST);

  // Ready is gated by rst_n so nothing is accepted while the block is held in reset.
  assign cpu_ready   = rst_n && !w_slot;
  assign w_cpu_acc   = cpu_valid && cpu_ready;
  assign w_clr_grant = rst_n && (r_state == S_CLEAR) && !w_slot && !w_cpu_acc;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_cnt;
    mem_wdata = r_color;
    if (rst_n) begin
      if (w_slot) begin
        mem_en   = 1'b1;
        mem_addr = w_disp_addr;
      end else if (w_cpu_acc) begin
        mem_en    = w_cpu_inrange;
        mem_we    = w_cpu_inrange && cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end else if (w_clr_grant) begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
    end
  end

  // Out-of-range reads never touch the RAM, so their result is forced to zero.
  assign w_rd_val   = r_rd_oor ? '0 : mem_rdata;
  assign cpu_rvalid = r_rd_pend;
  assign cpu_rdata  = r_rd_pend ? w_rd_val : r_rdata;
  assign pix_data   = r_pix_data;
  assign pix_valid  = r_pix_valid;
  assign clr_busy   = r_busy;
  assign clr_done   = r_done;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_rd   <= 1'b0;
      r_act_d1    <= 1'b0;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_disp_rd   <= w_slot;
      r_act_d1    <= active;
      r_pix_valid <= r_act_d1;
      if (!r_act_d1)
        r_pix_data <= '0;
      else if (r_disp_rd)
        r_pix_data <= mem_rdata;
      r_rd_pend <= w_cpu_acc && !cpu_we;
      r_rd_oor  <= !w_cpu_inrange;
      if (r_rd_pend)
        r_rdata <= w_rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_color <= clr_color;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (w_clr_grant) begin
            if (r_cnt == FB_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: arbitration vector table, pixel scan, CPU
// transactions, full clear and reset mid-clear, against a behavioural 1-cycle RAM.
module tb_vga_fb_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          active = 1'b0;
  logic [9:0]    x = '0;
  logic [9:0]    y = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          cpu_valid = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int checks = 0;
  int failures = 0;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .active(active), .x(x), .y(y),
    .pix_data(pix_data), .pix_valid(pix_valid),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port read-first RAM with one-cycle read latency; pl_* is a bench-only backdoor.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic cpu_op(input string nm, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    @(negedge clk);
    active = 1'b0; cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    #1 check({nm, "_ready"}, cpu_ready, 1);
    @(negedge clk);
    cpu_valid = 1'b0; cpu_we = 1'b0;
    #1 check({nm, "_rvalid"}, cpu_rvalid, we ? 0 : 1);
    if (!we) check({nm, "_rdata"}, cpu_rdata, exp_rd);
    @(negedge clk);
    #1 check({nm, "_rvalid_drop"}, cpu_rvalid, 0);
  endtask

  typedef struct {
    logic          act;
    logic [9:0]    vx;
    logic [9:0]    vy;
    logic          v;
    logic          we;
    logic [AW-1:0] addr;
    logic          e_ready;
    logic          e_en;
    logic          e_we;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int busy_cnt, done_cnt, bad;
    vecs[0]  = '{1'b0, 10'd0,   10'd0,   1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 15'd0};
    vecs[1]  = '{1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 15'd100,   1'b0, 1'b1, 1'b0, 15'd0};
    vecs[2]  = '{1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 15'd100,   1'b1, 1'b1, 1'b1, 15'd100};
    vecs[3]  = '{1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 15'd100,   1'b1, 1'b1, 1'b1, 15'd100};
    vecs[4]  = '{1'b1, 10'd4,   10'd0,   1'b1, 1'b0, 15'd100,   1'b0, 1'b1, 1'b0, 15'd1};
    vecs[5]  = '{1'b1, 10'd5,   10'd4,   1'b1, 1'b0, 15'd100,   1'b1, 1'b1, 1'b0, 15'd100};
    vecs[6]  = '{1'b1, 10'd8,   10'd4,   1'b0, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd162};
    vecs[7]  = '{1'b1, 10'd636, 10'd479, 1'b0, 1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd19199};
    vecs[8]  = '{1'b1, 10'd639, 10'd479, 1'b0, 1'b0, 15'd0,     1'b1, 1'b0, 1'b0, 15'd0};
    vecs[9]  = '{1'b0, 10'd4,   10'd0,   1'b1, 1'b1, 15'd19200, 1'b1, 1'b0, 1'b0, 15'd0};
    vecs[10] = '{1'b0, 10'd0,   10'd0,   1'b1, 1'b0, 15'd19199, 1'b1, 1'b1, 1'b0, 15'd19199};
    vecs[11] = '{1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 15'd32767, 1'b1, 1'b0, 1'b0, 15'd0};

    // Reset: outputs quiet even with requests and a display slot presented.
    active = 1'b1; x = '0; cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_pix", {pix_valid, pix_data}, 0);
    check("rst_cpu_rd", {cpu_rvalid, cpu_rdata}, 0);
    check("rst_clr", {clr_busy, clr_done}, 0);
    active = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_cpu_ready", cpu_ready, 1);
    check("idle_mem_en", mem_en, 0);

    // Pixel scan x=0..7 on row 0, then blanking.
    preload(15'd0, 8'h11);
    preload(15'd1, 8'h22);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        int k;
        k = j - 2;
        check($sformatf("pix_data_%0d", k), pix_data, (k < 4) ? 8'h11 : (k < 8) ? 8'h22 : 8'h00);
        check($sformatf("pix_valid_%0d", k), pix_valid, (k < 8) ? 1 : 0);
      end
      active = (j < 8); x = 10'(j); y = '0;
    end

    // cpu_ready drops exactly on display slots while a request is held.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      active = 1'b1; x = 10'(i); y = '0; cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd7;
      #1 check($sformatf("ready_x%0d", i), cpu_ready, (i % 4 != 0) ? 1 : 0);
    end

    // Arbitration vector table.
    cpu_wdata = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      active = vecs[i].act; x = vecs[i].vx; y = vecs[i].vy;
      cpu_valid = vecs[i].v; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_ready", i), cpu_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_en_we", i), {mem_en, mem_we}, {vecs[i].e_en, vecs[i].e_we});
      if (vecs[i].e_en) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].e_addr);
    end
    @(negedge clk);
    active = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;

    // CPU write/read, then out-of-range accesses.
    cpu_op("wr100", 1'b1, 15'd100, 8'hA5, 8'h00);
    cpu_op("rd100", 1'b0, 15'd100, 8'h00, 8'hA5);
    cpu_op("rd19200", 1'b0, 15'd19200, 8'h00, 8'h00);
    cpu_op("wr19200", 1'b1, 15'd19200, 8'h5A, 8'h00);
    check("ram19200_untouched", ram[19200], 0);
    check("ram100", ram[100], 8'hA5);

    // Full clear with a second clr_start mid-way that must be ignored.
    @(negedge clk);
    clr_start = 1'b1; clr_color = 8'h3C;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 19300; c++) begin
      @(negedge clk);
      busy_cnt += int'(clr_busy);
      done_cnt += int'(clr_done);
      clr_start = (c == 100);
      clr_color = (c == 100) ? 8'hFF : 8'h3C;
    end
    clr_start = 1'b0;
    check("clr_busy_cycles", busy_cnt, 19200);
    check("clr_done_pulses", done_cnt, 1);
    bad = 0;
    for (int a = 0; a < 19200; a++) if (ram[a] !== 8'h3C) bad++;
    check("clr_fill_bad_words", bad, 0);

    // Reset after 500 clear writes: busy drops at once, the rest stays intact.
    @(negedge clk);
    clr_start = 1'b1; clr_color = 8'h55;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midclr_busy", clr_busy, 0);
    check("midclr_mem_en", mem_en, 0);
    check("midclr_ram499", ram[499], 8'h55);
    check("midclr_ram500", ram[500], 8'h3C);
    check("midclr_ram19199", ram[19199], 8'h3C);
    @(negedge clk);
    rst_n = 1'b1;
    clr_start = 1'b1; clr_color = 8'h77;
    @(negedge clk);
    clr_start = 1'b0;
    #1;
    check("restart_busy", clr_busy, 1);
    check("restart_write", {mem_en, mem_we}, 2'b11);
    check("restart_addr", mem_addr, 0);
    check("restart_data", mem_wdata, 8'h77);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
